// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam int          PC_WIDTH    = 32;
    localparam logic [31:0] NOP         = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with reset / redirect / advance / hold selection.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] target_i,
    input  logic                advance_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_inc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // Plain 32-bit add: the PC wraps from the top of the address space to 0.
    assign pc_inc_o = pc_q + PC_WIDTH'(INSTR_BYTES);
    assign pc_o     = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ~PC_WIDTH'(INSTR_BYTES - 1);
        end else if (advance_i) begin
            pc_d = pc_inc_o;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: FSM, IF/ID register and optional performance counters.
// Counters are built only when FETCH_PERF_CNT_EN is defined; otherwise they read 0.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 256
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        HaltReq,
    input  logic [31:0] IMInstruction,
    output logic [31:0] IMAddress,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCPlus4Out,
    output logic        ValidOut,
    output logic        Halted,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    if ((RESET_PC & 32'h3) != 32'h0 || IM_WORDS < 1) begin : g_bad_cfg
        $error("fetch_sequencer: RESET_PC must be word aligned and IM_WORDS positive");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         redirect;
    logic         advance;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (Clk),
        .srst       (Reset),
        .redirect_i (redirect),
        .target_i   (BranchTarget),
        .advance_i  (advance),
        .pc_o       (pc),
        .pc_inc_o   (pc_inc)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        redirect = 1'b0;
        advance  = 1'b0;
        case (state_q)
            BOOT: state_d = HaltReq ? HALT : RUN;
            RUN, STALL: begin
                if (HaltReq) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (BranchTaken) begin
                    // Whatever is in IF/ID is wrong-path once we redirect.
                    state_d  = RUN;
                    redirect = 1'b1;
                    valid_d  = 1'b0;
                end else if (Stall) begin
                    state_d = STALL;
                    if (Flush) begin
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = RUN;
                    advance = 1'b1;
                    instr_d = IMInstruction;
                    pc4_d   = pc_inc;
                    valid_d = ~Flush;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= BOOT;
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign IMAddress      = pc;
    assign InstructionOut = instr_q;
    assign PCPlus4Out     = pc4_q;
    assign ValidOut       = valid_q;
    assign Halted         = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic        active;
    logic        fetch_evt;
    logic        stall_evt;
    logic        flush_evt;
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    assign active    = (state_q == RUN) || (state_q == STALL);
    assign fetch_evt = advance && !Flush;
    assign stall_evt = active && Stall;
    // Halt outranks everything, so a flush or redirect alongside HaltReq is not counted.
    assign flush_evt = active && !HaltReq && (BranchTaken || Flush);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_evt) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_evt) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign FetchCount = '0;
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table followed by randomized traffic vs a reference model.
module tb_fetch_sequencer;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, BranchTaken, HaltReq;
    logic [31:0] BranchTarget;
    logic [31:0] IMInstruction;
    logic [31:0] IMAddress, InstructionOut, PCPlus4Out;
    logic        ValidOut, Halted;
    logic [31:0] FetchCount, StallCount, FlushCount;

    logic [31:0] im [0:255];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign IMInstruction = im[IMAddress[9:2]];

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .IM_WORDS (256)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (Stall),
        .Flush          (Flush),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .HaltReq        (HaltReq),
        .IMInstruction  (IMInstruction),
        .IMAddress      (IMAddress),
        .InstructionOut (InstructionOut),
        .PCPlus4Out     (PCPlus4Out),
        .ValidOut       (ValidOut),
        .Halted         (Halted),
        .FetchCount     (FetchCount),
        .StallCount     (StallCount),
        .FlushCount     (FlushCount)
    );

    typedef struct {
        bit          rst, stall, flush, br;
        logic [31:0] tgt;
        bit          halt;
        int          reps;
        logic [31:0] addr, instr, pc4;
        bit          valid, halted;
        int          fc, sc, flc;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [0:NV-1];

    function automatic vec_t mk(input bit r, s, f, b, input logic [31:0] t, input bit h, input int reps,
                                input logic [31:0] a, i, p, input bit v, hd, input int fc, sc, flc);
        vec_t x;
        x.rst = r; x.stall = s; x.flush = f; x.br = b; x.tgt = t; x.halt = h; x.reps = reps;
        x.addr = a; x.instr = i; x.pc4 = p; x.valid = v; x.halted = hd;
        x.fc = fc; x.sc = sc; x.flc = flc;
        return x;
    endfunction

    task automatic drive(input bit r, s, f, b, input logic [31:0] t, input bit h);
        Reset = r; Stall = s; Flush = f; BranchTaken = b; BranchTarget = t; HaltReq = h;
    endtask

    task automatic compare(input string tag, input logic [31:0] ea, ei, ep, input bit ev, eh,
                           input int ef, es, efl);
        logic [31:0] xf, xs, xfl;
        xf  = PERF ? 32'(ef)  : 32'd0;
        xs  = PERF ? 32'(es)  : 32'd0;
        xfl = PERF ? 32'(efl) : 32'd0;
        checks++;
        if (IMAddress !== ea || InstructionOut !== ei || PCPlus4Out !== ep || ValidOut !== ev ||
            Halted !== eh || FetchCount !== xf || StallCount !== xs || FlushCount !== xfl) begin
            errors++;
            $display("FAIL %s: got addr=%h instr=%h pc4=%h valid=%b halted=%b cnt=%0d/%0d/%0d, expected addr=%h instr=%h pc4=%h valid=%b halted=%b cnt=%0d/%0d/%0d",
                     tag, IMAddress, InstructionOut, PCPlus4Out, ValidOut, Halted, FetchCount, StallCount,
                     FlushCount, ea, ei, ep, ev, eh, xf, xs, xfl);
        end
    endtask

    // Reference model: 0 = booting, 1 = fetching (running or stalled), 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid;
    int          m_fc, m_sc, m_flc;

    task automatic model_step(input bit r, s, f, b, input logic [31:0] t, input bit h);
        if (r) begin
            m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_fc = 0; m_sc = 0; m_flc = 0;
        end else if (m_mode == 0) begin
            m_mode = h ? 2 : 1;
        end else if (m_mode == 1) begin
            if (s) m_sc++;
            if (h) begin
                m_valid = 1'b0;
                m_mode  = 2;
            end else if (b) begin
                m_pc    = {t[31:2], 2'b00};
                m_valid = 1'b0;
                m_flc++;
            end else if (s) begin
                if (f) begin
                    m_valid = 1'b0;
                    m_flc++;
                end
            end else begin
                m_instr = im[(m_pc >> 2) % 256];
                m_pc4   = m_pc + 32'd4;
                m_valid = !f;
                if (f) m_flc++; else m_fc++;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) im[i] = 32'hA000_0000 | 32'(i);
        im[0] = 32'h8C05_0014;
        im[1] = 32'h8C0A_0014;
        im[2] = 32'h0000_0000;

        //                rst   stall flush br    target         halt reps addr           instr          pc4            v     halted fc sc flc
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h4,         32'h8C05_0014, 32'h4,         1'b1, 1'b0, 1, 0, 0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h8,         32'h8C0A_0014, 32'h8,         1'b1, 1'b0, 2, 0, 0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h8,         32'h8C0A_0014, 32'h8,         1'b1, 1'b0, 2, 1, 0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h8,         32'h8C0A_0014, 32'h8,         1'b1, 1'b0, 2, 2, 0);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h8,         32'h8C0A_0014, 32'h8,         1'b1, 1'b0, 2, 3, 0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'hC,         32'h0,         32'hC,         1'b1, 1'b0, 3, 3, 0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h43,        1'b0, 1, 32'h40,        32'h0,         32'hC,         1'b0, 1'b0, 3, 4, 1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h44,        32'hA000_0010, 32'h44,        1'b1, 1'b0, 4, 4, 1);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h4,         1'b0, 1, 32'h4,         32'hA000_0010, 32'h44,        1'b0, 1'b0, 4, 4, 2);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1, 32'h8,         32'h8C0A_0014, 32'h8,         1'b0, 1'b0, 4, 4, 3);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'hC,         32'h0,         32'hC,         1'b1, 1'b0, 5, 4, 3);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h10,        32'hA000_0003, 32'h10,        1'b1, 1'b0, 6, 4, 3);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1, 32'h10,        32'hA000_0003, 32'h10,        1'b0, 1'b1, 6, 4, 3);
        vecs[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h80,        1'b0, 10, 32'h10,       32'hA000_0003, 32'h10,        1'b0, 1'b1, 6, 4, 3);
        vecs[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h3FC,       1'b0, 1, 32'h3FC,       32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 1);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h400,       32'hA000_00FF, 32'h400,       1'b1, 1'b0, 1, 0, 1);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h404,       32'h8C05_0014, 32'h404,       1'b1, 1'b0, 2, 0, 1);
        vecs[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 0, 0, 0);
        vecs[23] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 0);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 1);
        vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'hA000_00FF, 32'h0,         1'b1, 1'b0, 1, 0, 1);
        vecs[27] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'hA000_00FF, 32'h0,         1'b1, 1'b0, 1, 1, 1);
        vecs[28] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1, 32'h0,         32'hA000_00FF, 32'h0,         1'b0, 1'b0, 1, 2, 2);
        vecs[29] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1, 32'h4,         32'h8C05_0014, 32'h4,         1'b1, 1'b0, 2, 2, 2);

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt, vecs[i].halt);
                @(posedge Clk);
                #1;
                $display("vec%0d.%0d addr=%h instr=%h pc4=%h valid=%b halted=%b", i, k, IMAddress,
                         InstructionOut, PCPlus4Out, ValidOut, Halted);
                compare($sformatf("vec%0d.%0d", i, k), vecs[i].addr, vecs[i].instr, vecs[i].pc4,
                        vecs[i].valid, vecs[i].halted, vecs[i].fc, vecs[i].sc, vecs[i].flc);
            end
        end

        // Randomized traffic against the reference model, starting from a reset.
        for (int n = 0; n < 3000; n++) begin
            bit          r, s, f, b, h;
            logic [31:0] t;
            r = (n == 0) || ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 15);
            b = ($urandom_range(0, 99) < 10);
            h = ($urandom_range(0, 99) < 1);
            t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(r, s, f, b, t, h);
            model_step(r, s, f, b, t, h);
            @(posedge Clk);
            #1;
            compare($sformatf("rand%0d", n), m_pc, m_instr, m_pc4, m_valid, (m_mode == 2),
                    m_fc, m_sc, m_flc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the word-addressed instruction memory (IM) in the single-issue MIPS pipeline. It owns the program counter and drives the IM byte address. It captures the combinational IM read data into the IF/ID pipeline register. It also applies stall, flush, branch-redirect and halt requests coming from the decode and execute stages.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- IM_WORDS, 256, IM depth in 32-bit words; the fetch address wraps within IM_WORDS*4 bytes

Ports (all synchronous to Clk; reset is synchronous, active-high):
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and IF/ID contents
- Flush  in  1  invalidate the IF/ID entry
- BranchTaken  in  1  redirect PC this cycle
- BranchTarget  in  32  redirect byte address; bits [1:0] are ignored and forced to 0
- HaltReq  in  1  stop fetching until Reset
- IMInstruction  in  32  combinational IM read data for IMAddress
- IMAddress  out  32  byte address to IM (IM indexes with [9:2])
- InstructionOut  out  32  IF/ID instruction
- PCPlus4Out  out  32  IF/ID PC+4 of that instruction
- ValidOut  out  1  IF/ID entry is a real instruction
- Halted  out  1  FSM is in HALT
- FetchCount, StallCount, FlushCount  out  32 each  performance counters (see Configuration)

## Operation
FSM states are BOOT, RUN, STALL and HALT.
- Reset (any state, any inputs) puts the block in BOOT:
  - PC=RESET_PC, InstructionOut=0, PCPlus4Out=0, ValidOut=0, Halted=0, counters=0.
- BOOT lasts one cycle with no capture, then goes to RUN (or to HALT if HaltReq is high).
- RUN, priority high to low:
  - HaltReq: go to HALT; IF/ID ValidOut<=0.
  - BranchTaken: PC<=BranchTarget&~3; ValidOut<=0 (wrong-path squash); stay in RUN.
  - Stall: go to STALL; PC and IF/ID hold.
  - Otherwise advance: InstructionOut<=IMInstruction, PCPlus4Out<=PC+4, ValidOut<=~Flush, PC<=PC+4.
- STALL:
  - Same priorities as RUN.
  - Stall low: return to RUN and advance in that same cycle.
  - BranchTaken during STALL: redirects and squashes immediately.
  - Flush during STALL: ValidOut<=0; PC holds.
- HALT: PC, IF/ID and counters frozen; Halted=1; only Reset exits.
- Arithmetic and limits:
  - PC+4 is 32-bit and wraps 32'hFFFF_FFFC -> 0.
  - IMAddress[1:0] is always 0.
  - IM aliasing above IM_WORDS*4 bytes is expected and not flagged.
- Flush and advance in the same cycle: PC still advances and the captured entry is marked invalid.

## Timing
- IMAddress = PC register, combinational, with zero added latency.
- Fetch-to-IF/ID latency is 1 cycle: the instruction at PC appears on InstructionOut after the next rising edge.
- Redirect penalty is 1 bubble:
  - Cycle N: BranchTaken asserted.
  - Edge N: PC=target, ValidOut=0.
  - Edge N+1: target instruction valid.
- Stall takes effect on the same edge it is sampled; outputs are unchanged for every cycle Stall is high.
- Reset mid-operation discards the in-flight IF/ID entry on that edge; the first valid instruction appears 2 edges after Reset deasserts (BOOT, then capture).

## Configuration
- FETCH_PERF_CNT_EN defined:
  - FetchCount increments on each edge where a valid entry is captured.
  - StallCount increments on each cycle with Stall high in RUN or STALL.
  - FlushCount increments on each Flush or BranchTaken squash.
  - All counters wrap at 2^32, are cleared by Reset and frozen in HALT.
- FETCH_PERF_CNT_EN undefined: the counter ports remain and are tied to 0; no counter registers are built.

## Structure
- Shared package (fetch_pkg):
  - FSM state enum (BOOT/RUN/STALL/HALT, 2 bits).
  - Constants: INSTR_BYTES=4, PC_WIDTH=32, NOP=32'h0000_0000.
- One natural sub-module, fetch_pc_reg: the PC register with next-PC mux (reset/redirect/hold/+4).
- The top level holds the FSM, the IF/ID register and the optional counters.

## Test plan
- Reset with IM[0..2]=8C05_0014, 8C0A_0014, 0 -> IMAddress 0,4,8 on successive cycles; InstructionOut=8C05_0014 with PCPlus4Out=4 and ValidOut=1 at the second edge after Reset falls.
- Stall high for 3 cycles at PC=8 -> IMAddress stays 8, IF/ID unchanged, StallCount=3 (with macro); on release the next capture is IM[2] with PCPlus4Out=12.
- BranchTaken with BranchTarget=32'h0000_0043 while Stall=1 -> PC=0x40, ValidOut=0 next edge, then IM[16] valid with PCPlus4Out=0x44.
- Flush alone in RUN at PC=4 -> PC advances to 8, ValidOut=0 for that entry, FlushCount=1.
- HaltReq at PC=0x10 -> Halted=1, PC frozen at 0x10 for 10 cycles, ValidOut=0; Reset -> PC=RESET_PC, Halted=0.
- PC=0x3FC advancing -> IMAddress=0x400, which aliases IM[0] (same instruction captured as for PC=0); PCPlus4Out=0x400.
